// File: rtl/time_disp_pkg.sv
// rtl/time_disp_pkg.sv - glyph codes, dimensions and font table for the time overlay
package time_disp_pkg;

  localparam logic [3:0] GLYPH_COLON = 4'd10;
  localparam logic [3:0] GLYPH_BLANK = 4'd11;
  localparam int         GLYPH_W     = 8;
  localparam int         GLYPH_H     = 16;

  // Seven-segment style outline of a digit: {a, b, c, d, e, f, g}
  function automatic logic [6:0] digit_segments(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1111110;
      4'd1:    s = 7'b0110000;
      4'd2:    s = 7'b1101101;
      4'd3:    s = 7'b1111001;
      4'd4:    s = 7'b0110011;
      4'd5:    s = 7'b1011011;
      4'd6:    s = 7'b1011111;
      4'd7:    s = 7'b1110000;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1111011;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  // Font table: one 8-pixel row of a 8x16 glyph, bit 7 leftmost.
  // Rows 0, 1, 14 and 15 stay empty so adjacent glyphs never touch.
  function automatic logic [7:0] font_row(input logic [3:0] code, input logic [3:0] row);
    logic [6:0] s;
    logic [7:0] r;
    logic [7:0] upper_sides;
    logic [7:0] lower_sides;
    r           = 8'h00;
    s           = digit_segments(code);
    upper_sides = (s[1] ? 8'h60 : 8'h00) | (s[5] ? 8'h06 : 8'h00);
    lower_sides = (s[2] ? 8'h60 : 8'h00) | (s[4] ? 8'h06 : 8'h00);
    if (code == GLYPH_COLON) begin
      if (row == 4'd4 || row == 4'd5 || row == 4'd10 || row == 4'd11) r = 8'h18;
    end else if (code <= 4'd9) begin
      case (row)
        4'd2:                      r = s[6] ? 8'h7E : 8'h00;
        4'd3, 4'd4, 4'd5, 4'd6:    r = upper_sides;
        4'd7:                      r = s[0] ? 8'h7E : upper_sides;
        4'd8, 4'd9, 4'd10, 4'd11,
        4'd12:                     r = lower_sides;
        4'd13:                     r = s[3] ? 8'h7E : 8'h00;
        default:                   r = 8'h00;
      endcase
    end
    return r;
  endfunction

  // A snapshot nibble that is not valid BCD renders as an empty cell
  function automatic logic [3:0] digit_code(input logic [3:0] d);
    return (d > 4'd9) ? GLYPH_BLANK : d;
  endfunction

endpackage

// File: rtl/digit_font_rom.sv
// rtl/digit_font_rom.sv - registered glyph row lookup, pipeline stage 2
module digit_font_rom
  import time_disp_pkg::*;
(
  input  logic       clk,
  input  logic [3:0] code,
  input  logic [3:0] row,
  output logic [7:0] bits
);

  // One-cycle font lookup; downstream gating makes a reset here unnecessary
  always_ff @(posedge clk) begin
    bits <= font_row(code, row);
  end

endmodule

// File: rtl/time_overlay_render.sv
// rtl/time_overlay_render.sv - HH:MM:SS text overlay with sync delay line
module time_overlay_render
  import time_disp_pkg::*;
#(
  parameter int          ORIGIN_X   = 256,
  parameter int          ORIGIN_Y   = 224,
  parameter int          SCALE_LOG2 = 1,   // 0..2 only
  parameter int          LATCH_Y    = 480,
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        video_on,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [3:0]  hours_tens,
  input  logic [3:0]  hours_units,
  input  logic [3:0]  minutes_tens,
  input  logic [3:0]  minutes_units,
  input  logic [3:0]  seconds_tens,
  input  logic [3:0]  seconds_units,
  output logic [11:0] rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int          CW   = GLYPH_W << SCALE_LOG2;
  localparam int          CH   = GLYPH_H << SCALE_LOG2;
  localparam logic [10:0] X_LO = 11'(ORIGIN_X);
  localparam logic [10:0] X_HI = 11'(ORIGIN_X + 8 * CW);
  localparam logic [10:0] Y_LO = 11'(ORIGIN_Y);
  localparam logic [10:0] Y_HI = 11'(ORIGIN_Y + CH);

  logic [3:0] snap_ht, snap_hu, snap_mt, snap_mu, snap_st, snap_su;

  logic [9:0] dx, dy;
  logic       in_box_next;
  logic [2:0] slot_next, col_next;
  logic [3:0] row_next;

  logic       in_box_1, video_on_1, hsync_1, vsync_1;
  logic [2:0] slot_1, col_1;
  logic [3:0] row_1;

  logic       in_box_2, video_on_2, hsync_2, vsync_2;
  logic [2:0] col_2;

  logic [3:0] glyph_code;
  logic [7:0] row_bits;
  logic       pixel_bit;

  // Frame snapshot in vertical blanking so the displayed time never tears
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_ht <= '0; snap_hu <= '0;
      snap_mt <= '0; snap_mu <= '0;
      snap_st <= '0; snap_su <= '0;
    end else if (pixel_x == 10'd0 && pixel_y == 10'(LATCH_Y)) begin
      snap_ht <= hours_tens;   snap_hu <= hours_units;
      snap_mt <= minutes_tens; snap_mu <= minutes_units;
      snap_st <= seconds_tens; snap_su <= seconds_units;
    end
  end

  // Box-relative coordinates; scaling is a pure shift so no dividers appear
  always_comb begin
    dx          = pixel_x - 10'(ORIGIN_X);
    dy          = pixel_y - 10'(ORIGIN_Y);
    in_box_next = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI) &&
                  ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);
    slot_next   = 3'(dx >> (3 + SCALE_LOG2));
    col_next    = 3'(dx >> SCALE_LOG2);
    row_next    = 4'(dy >> SCALE_LOG2);
  end

  // Stage 1: geometry plus the delay line start; syncs idle high in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_box_1   <= 1'b0;
      slot_1     <= '0;
      col_1      <= '0;
      row_1      <= '0;
      video_on_1 <= 1'b0;
      hsync_1    <= 1'b1;
      vsync_1    <= 1'b1;
    end else begin
      in_box_1   <= in_box_next;
      slot_1     <= slot_next;
      col_1      <= col_next;
      row_1      <= row_next;
      video_on_1 <= video_on;
      hsync_1    <= hsync_in;
      vsync_1    <= vsync_in;
    end
  end

  // Slot to glyph: H H : M M : S S
  always_comb begin
    glyph_code = GLYPH_BLANK;
    case (slot_1)
      3'd0:    glyph_code = digit_code(snap_ht);
      3'd1:    glyph_code = digit_code(snap_hu);
      3'd2:    glyph_code = GLYPH_COLON;
      3'd3:    glyph_code = digit_code(snap_mt);
      3'd4:    glyph_code = digit_code(snap_mu);
      3'd5:    glyph_code = GLYPH_COLON;
      3'd6:    glyph_code = digit_code(snap_st);
      3'd7:    glyph_code = digit_code(snap_su);
      default: glyph_code = GLYPH_BLANK;
    endcase
  end

  digit_font_rom u_font (
    .clk  (clk),
    .code (glyph_code),
    .row  (row_1),
    .bits (row_bits)
  );

  // Stage 2: carry the side signals alongside the ROM lookup
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_box_2   <= 1'b0;
      col_2      <= '0;
      video_on_2 <= 1'b0;
      hsync_2    <= 1'b1;
      vsync_2    <= 1'b1;
    end else begin
      in_box_2   <= in_box_1;
      col_2      <= col_1;
      video_on_2 <= video_on_1;
      hsync_2    <= hsync_1;
      vsync_2    <= vsync_1;
    end
  end

  // Bit 7 of the font row is the leftmost pixel of the cell
  always_comb begin
    pixel_bit = row_bits[3'd7 - col_2];
  end

  // Stage 3: colour select; blanking forces black regardless of glyph
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb       <= 12'h000;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      if (!video_on_2)               rgb <= 12'h000;
      else if (in_box_2 && pixel_bit) rgb <= FG_COLOR;
      else                           rgb <= BG_COLOR;
      hsync_out <= hsync_2;
      vsync_out <= vsync_2;
    end
  end

endmodule

// File: tb/tb_time_overlay_render.sv
// tb/tb_time_overlay_render.sv - directed table-driven bench for time_overlay_render
module tb_time_overlay_render;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  pixel_x, pixel_y;
  logic        video_on, hsync_in, vsync_in;
  logic [3:0]  hours_tens, hours_units, minutes_tens, minutes_units, seconds_tens, seconds_units;
  logic [11:0] rgb;
  logic        hsync_out, vsync_out;

  int checks = 0;
  int errors = 0;

  time_overlay_render dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .video_on      (video_on),
    .hsync_in      (hsync_in),
    .vsync_in      (vsync_in),
    .hours_tens    (hours_tens),
    .hours_units   (hours_units),
    .minutes_tens  (minutes_tens),
    .minutes_units (minutes_units),
    .seconds_tens  (seconds_tens),
    .seconds_units (seconds_units),
    .rgb           (rgb),
    .hsync_out     (hsync_out),
    .vsync_out     (vsync_out)
  );

  always #20 clk = ~clk;

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        von;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [11:0] got, input logic [11:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic check_px(input string name, input logic [9:0] x, input logic [9:0] y,
                          input logic von, input logic [11:0] want);
    pixel_x  = x;
    pixel_y  = y;
    video_on = von;
    repeat (3) tick();
    checks++;
    if (rgb !== want) begin
      errors++;
      $display("FAIL %s (%0d,%0d) rgb got %h want %h", name, x, y, rgb, want);
    end
  endtask

  task automatic latch(input logic [3:0] ht, hu, mt, mu, st, su);
    hours_tens = ht;   hours_units = hu;
    minutes_tens = mt; minutes_units = mu;
    seconds_tens = st; seconds_units = su;
    pixel_x  = 10'd0;
    pixel_y  = 10'd480;
    video_on = 1'b0;
    tick();
    pixel_x  = 10'd5;
    pixel_y  = 10'd0;
  endtask

  initial begin
    reset = 1'b1;
    pixel_x = 10'd5; pixel_y = 10'd0; video_on = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1;
    hours_tens = 0; hours_units = 0; minutes_tens = 0; minutes_units = 0;
    seconds_tens = 0; seconds_units = 0;

    // Vectors for a snapshot of 12:34:56 at 2x scale (cells 16x32, box 256..383 x 224..255)
    vecs[0]  = '{10'd295, 10'd232, 1'b1, 12'hFFF}; // colon slot 2 row 4 col 3
    vecs[1]  = '{10'd289, 10'd232, 1'b1, 12'h000}; // colon col 0
    vecs[2]  = '{10'd255, 10'd230, 1'b1, 12'h000}; // left of box
    vecs[3]  = '{10'd384, 10'd230, 1'b1, 12'h000}; // first column past box
    vecs[4]  = '{10'd300, 10'd223, 1'b1, 12'h000}; // above box
    vecs[5]  = '{10'd300, 10'd256, 1'b1, 12'h000}; // below box
    vecs[6]  = '{10'd266, 10'd230, 1'b1, 12'hFFF}; // '1' right stroke row 3 col 5
    vecs[7]  = '{10'd370, 10'd238, 1'b1, 12'hFFF}; // '6' middle bar row 7 col 1
    vecs[8]  = '{10'd295, 10'd232, 1'b0, 12'h000}; // blanking over a lit colon pixel
    vecs[9]  = '{10'd306, 10'd228, 1'b1, 12'hFFF}; // '3' top bar row 2 col 1
    vecs[10] = '{10'd306, 10'd232, 1'b1, 12'h000}; // '3' has no upper-left stroke

    #5;
    check_val("reset_rgb", rgb, 12'h000);
    check_val("reset_hsync", {11'd0, hsync_out}, 12'h001);
    check_val("reset_vsync", {11'd0, vsync_out}, 12'h001);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Power-up snapshot is 00:00:00 with the leading zero drawn
    check_px("zero_hours_top", 10'd258, 10'd228, 1'b1, 12'hFFF);

    latch(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6);
    for (int i = 0; i < 11; i++) begin
      check_px($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].von, vecs[i].exp);
    end

    // Glyph rows 0 and 15 are empty in every slot
    for (int s = 0; s < 8; s++) begin
      check_px($sformatf("row0_slot%0d", s), 10'(256 + 16 * s + 4), 10'd224, 1'b1, 12'h000);
      check_px($sformatf("row15_slot%0d", s), 10'(256 + 16 * s + 6), 10'd254, 1'b1, 12'h000);
    end

    // Mid-frame digit change stays hidden until the next latch row
    pixel_y = 10'd100; pixel_x = 10'd40;
    seconds_units = 4'd7;
    tick();
    check_px("hold_six", 10'd370, 10'd238, 1'b1, 12'hFFF);
    latch(4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7);
    check_px("show_seven", 10'd370, 10'd238, 1'b1, 12'h000);
    check_px("seven_top", 10'd370, 10'd228, 1'b1, 12'hFFF);

    // Invalid BCD turns slot 4 into an empty cell
    check_px("four_mid_before", 10'd322, 10'd238, 1'b1, 12'hFFF);
    latch(4'd1, 4'd2, 4'd3, 4'hC, 4'd5, 4'd6);
    for (int y = 224; y < 256; y += 2) begin
      for (int x = 320; x < 336; x++) begin
        check_px("blank_slot4", 10'(x), 10'(y), 1'b1, 12'h000);
      end
    end

    // Sync delay line: exactly three clocks
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    tick();
    check_val("hsync_d1", {11'd0, hsync_out}, 12'h001);
    tick();
    check_val("hsync_d2", {11'd0, hsync_out}, 12'h001);
    check_val("vsync_d2", {11'd0, vsync_out}, 12'h001);
    tick();
    check_val("hsync_d3", {11'd0, hsync_out}, 12'h000);
    check_val("vsync_d3", {11'd0, vsync_out}, 12'h000);
    hsync_in = 1'b1;
    vsync_in = 1'b1;

    // Asynchronous reset mid-line, then three-clock recovery
    hsync_in = 1'b0;
    check_px("pre_reset_colon", 10'd295, 10'd232, 1'b1, 12'hFFF);
    check_val("pre_reset_hsync", {11'd0, hsync_out}, 12'h000);
    #10;
    reset = 1'b1;
    #1;
    check_val("async_rgb", rgb, 12'h000);
    check_val("async_hsync", {11'd0, hsync_out}, 12'h001);
    check_val("async_vsync", {11'd0, vsync_out}, 12'h001);
    hsync_in = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check_val("rel_c1", rgb, 12'h000);
    tick();
    check_val("rel_c2", rgb, 12'h000);
    tick();
    check_val("rel_c3", rgb, 12'hFFF);
    // Snapshot cleared: slot 1 is '0' again, whose middle row has no bar
    check_px("post_reset_zero", 10'd278, 10'd238, 1'b1, 12'h000);
    check_px("post_reset_zero_top", 10'd274, 10'd228, 1'b1, 12'hFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
